// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Brief   : Data-memory responder for the core load/store interface. Accepts
//           one request at a time and performs B/H/W access on a word array.
//           Load data is sign/zero extended, and the response is registered
//           LATENCY edges after the accept edge.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] C_CNT_INIT = CW'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_we;
    logic [2:0]    r_f3;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_fire;
    logic          w_hs;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic [31:0]   w_word;
    logic [31:0]   w_bshift;
    logic [31:0]   w_hshift;
    logic          w_err;
    logic [3:0]    w_be;
    logic [31:0]   w_wd;
    logic [31:0]   w_rdata;
    logic          w_unused_addr;

    // Address bits above the array wrap point are deliberately ignored.
    assign w_unused_addr = ^i_req_addr[31:AW+2];

    assign w_accept = (r_state == S_IDLE) && i_req_valid;
    // WAIT always lasts at least one cycle, so the access lands LATENCY edges after accept.
    assign w_fire   = (r_state == S_WAIT) && (r_cnt == CW'(0));
    assign w_hs     = (r_state == S_RESP) && i_resp_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_fire)   w_state_nxt = S_RESP;
            S_RESP:  if (w_hs)     w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: the responder is only ready while idle.
    always_comb begin
        o_req_ready = (r_state == S_IDLE);
    end

    // Request capture and latency countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_f3    <= 3'b000;
        end else if (w_accept) begin
            r_cnt   <= C_CNT_INIT;
            r_addr  <= i_req_addr[AW+1:0];
            r_wdata <= i_req_wdata;
            r_we    <= i_req_we;
            r_f3    <= i_req_funct3;
        end else if ((r_state == S_WAIT) && (r_cnt != CW'(0))) begin
            r_cnt   <= r_cnt - CW'(1);
        end
    end

    // Access decode: legality, store lane enables and load extraction.
    always_comb begin
        w_idx    = r_addr[AW+1:2];
        w_lane   = r_addr[1:0];
        w_word   = r_mem[w_idx];
        w_bshift = w_word >> {w_lane, 3'b000};
        w_hshift = w_word >> {r_addr[1], 4'b0000};
        w_err    = 1'b0;
        w_be     = 4'b0000;
        w_wd     = r_wdata;
        w_rdata  = 32'h0;
        case (r_f3)
            3'b000: begin
                w_be    = 4'b0001 << w_lane;
                w_wd    = {4{r_wdata[7:0]}};
                w_rdata = {{24{w_bshift[7]}}, w_bshift[7:0]};
            end
            3'b001: begin
                w_err   = r_addr[0];
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wd    = {2{r_wdata[15:0]}};
                w_rdata = {{16{w_hshift[15]}}, w_hshift[15:0]};
            end
            3'b010: begin
                w_err   = (r_addr[1:0] != 2'b00);
                w_be    = 4'b1111;
                w_rdata = w_word;
            end
            3'b100: begin
                w_err   = r_we;
                w_rdata = {24'h0, w_bshift[7:0]};
            end
            3'b101: begin
                w_err   = r_we | r_addr[0];
                w_rdata = {16'h0, w_hshift[15:0]};
            end
            default: w_err = 1'b1;
        endcase
    end

    // Array write; contents survive reset, and an aborted WAIT never reaches w_fire.
    always_ff @(posedge clk) begin
        if (w_fire && r_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
                end
            end
        end
    end

    // Response registers: loaded on the access edge, cleared on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_resp_valid <= 1'b0;
            o_resp_rdata <= 32'h0;
            o_resp_err   <= 1'b0;
        end else if (w_fire) begin
            o_resp_valid <= 1'b1;
            o_resp_err   <= w_err;
            o_resp_rdata <= (r_we || w_err) ? 32'h0 : w_rdata;
        end else if (w_hs) begin
            o_resp_valid <= 1'b0;
            o_resp_rdata <= 32'h0;
            o_resp_err   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Directed bench for dmem_responder. Instance 0 uses LATENCY=2,
//           instance 1 LATENCY=1, instance 2 LATENCY=3 (all DEPTH=256).
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk;
    logic        rst_n      [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        req_we     [3];
    logic [2:0]  req_funct3 [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    int vectors;
    int miscompares;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            dmem_responder #(
                .DEPTH  (256),
                .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 3))
            ) u_dut (
                .clk         (clk),
                .rst_n       (rst_n[g]),
                .i_req_valid (req_valid[g]),
                .o_req_ready (req_ready[g]),
                .i_req_addr  (req_addr[g]),
                .i_req_wdata (req_wdata[g]),
                .i_req_we    (req_we[g]),
                .i_req_funct3(req_funct3[g]),
                .o_resp_valid(resp_valid[g]),
                .i_resp_ready(resp_ready[g]),
                .o_resp_rdata(resp_rdata[g]),
                .o_resp_err  (resp_err[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request, measure edges from accept to resp_valid, then handshake.
    task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wd;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        lat = 0;
        while (!resp_valid[d] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid[d]) lat = -1;
        rd = resp_rdata[d];
        er = resp_err[d];
        @(negedge clk);
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; resp_ready[d] = 1'b0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0; req_we[d] = 1'b0;
            req_funct3[d] = 3'b000;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 ||
                resp_rdata[d] !== 32'h0 || resp_err[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset[%0d]: ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 0",
                         d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
            end
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        do_req(0, 1'b1, F_W, 32'h10, 32'hDEADBEEF, rd, er, lat);
        vectors++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_10: lat=%0d rdata=%h err=%b, want 2 00000000 0", lat, rd, er);
        end
        do_req(0, 1'b0, F_W, 32'h10, 32'h0, rd, er, lat);
        vectors++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_10: lat=%0d rdata=%h err=%b, want 2 deadbeef 0", lat, rd, er);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic er; int lat;
        do_req(0, 1'b1, F_B, 32'h13, 32'h00000080, rd, er, lat);
        vectors++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_13: rdata=%h err=%b, want 00000000 0", rd, er);
        end
        do_req(0, 1'b0, F_B, 32'h13, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL lb_13: rdata=%h err=%b, want ffffff80 0", rd, er);
        end
        do_req(0, 1'b0, F_BU, 32'h13, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h00000080 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL lbu_13: rdata=%h err=%b, want 00000080 0", rd, er);
        end
        do_req(0, 1'b0, F_W, 32'h10, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h80ADBEEF || er !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_after_sb: rdata=%h err=%b, want 80adbeef 0", rd, er);
        end
        do_req(0, 1'b0, F_HU, 32'h12, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h000080AD || er !== 1'b0) begin
            miscompares++;
            $display("FAIL lhu_12: rdata=%h err=%b, want 000080ad 0", rd, er);
        end
        do_req(0, 1'b0, F_H, 32'h12, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'hFFFF80AD || er !== 1'b0) begin
            miscompares++;
            $display("FAIL lh_12: rdata=%h err=%b, want ffff80ad 0", rd, er);
        end
        do_req(0, 1'b0, F_H, 32'h10, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'hFFFFBEEF || er !== 1'b0) begin
            miscompares++;
            $display("FAIL lh_10: rdata=%h err=%b, want ffffbeef 0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        do_req(0, 1'b0, F_H, 32'h11, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL lh_11_misaligned: rdata=%h err=%b, want 00000000 1", rd, er);
        end
        do_req(0, 1'b1, F_W, 32'h12, 32'h11111111, rd, er, lat);
        vectors++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL sw_12_misaligned: rdata=%h err=%b, want 00000000 1", rd, er);
        end
        do_req(0, 1'b1, F_BU, 32'h10, 32'h000000FF, rd, er, lat);
        vectors++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL store_bu: rdata=%h err=%b, want 00000000 1", rd, er);
        end
        do_req(0, 1'b0, F_W, 32'h10, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h80ADBEEF || er !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_after_err_stores: rdata=%h err=%b, want 80adbeef 0", rd, er);
        end
        do_req(0, 1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL load_f3_011: rdata=%h err=%b, want 00000000 1", rd, er);
        end
    endtask

    task automatic test_hold();
        logic [31:0] rd; logic er; int lat;
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_funct3[0] = F_W; req_addr[0] = 32'h10;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'h80ADBEEF) begin
            miscompares++;
            $display("FAIL hold_entry: valid=%b rdata=%h, want 1 80adbeef", resp_valid[0], resp_rdata[0]);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = F_W;
                req_addr[0] = 32'h10; req_wdata[0] = 32'h0BADF00D;
            end
            if (i == 3) req_valid[0] = 1'b0;
            @(posedge clk);
            #1;
            vectors++;
            if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'h80ADBEEF ||
                resp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: valid=%b rdata=%h err=%b ready=%b, want 1 80adbeef 0 0",
                         i, resp_valid[0], resp_rdata[0], resp_err[0], req_ready[0]);
            end
        end
        @(negedge clk);
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[0] = 1'b0;
        vectors++;
        if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'h0 || req_ready[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release: valid=%b rdata=%h ready=%b, want 0 00000000 1",
                     resp_valid[0], resp_rdata[0], req_ready[0]);
        end
        do_req(0, 1'b0, F_W, 32'h10, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h80ADBEEF || er !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_store: rdata=%h err=%b, want 80adbeef 0", rd, er);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er; int lat;
        do_req(0, 1'b1, F_W, 32'h400, 32'h12345678, rd, er, lat);
        do_req(0, 1'b0, F_W, 32'h000, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h12345678 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_lw_0: rdata=%h err=%b, want 12345678 0", rd, er);
        end
    endtask

    task automatic test_latency1();
        logic [31:0] rd; logic er; int lat;
        do_req(1, 1'b1, F_W, 32'h8, 32'hA5A5C3C3, rd, er, lat);
        vectors++;
        if (lat !== 1 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL lat1_sw: lat=%0d err=%b, want 1 0", lat, er);
        end
        do_req(1, 1'b0, F_B, 32'h9, 32'h0, rd, er, lat);
        vectors++;
        if (lat !== 1 || rd !== 32'hFFFFFFC3 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL lat1_lb: lat=%0d rdata=%h err=%b, want 1 ffffffc3 0", lat, rd, er);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat;
        do_req(2, 1'b1, F_W, 32'h20, 32'h55AA55AA, rd, er, lat);
        vectors++;
        if (lat !== 3 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL lat3_sw: lat=%0d err=%b, want 3 0", lat, er);
        end
        @(negedge clk);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_funct3[2] = F_W;
        req_addr[2] = 32'h20; req_wdata[2] = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (req_ready[2] !== 1'b0 || resp_valid[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL lat3_wait: ready=%b valid=%b, want 0 0", req_ready[2], resp_valid[2]);
        end
        #2;
        rst_n[2] = 1'b0;
        #1;
        vectors++;
        if (req_ready[2] !== 1'b1 || resp_valid[2] !== 1'b0 ||
            resp_rdata[2] !== 32'h0 || resp_err[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_reset: ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 0",
                     req_ready[2], resp_valid[2], resp_rdata[2], resp_err[2]);
        end
        @(negedge clk);
        rst_n[2] = 1'b1;
        do_req(2, 1'b0, F_W, 32'h20, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h55AA55AA || er !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_commit: rdata=%h err=%b, want 55aa55aa 0", rd, er);
        end
    endtask

    // Scenario sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_word();
        test_byte_half();
        test_errors();
        test_hold();
        test_wrap();
        test_latency1();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
